// File: rtl/stash_ctrl.sv
// Stopwatch lap controller: sequences the time counter and an external lap stash
// buffer through IDLE / RUN / STOP / BROWSE, with an inactivity timeout in BROWSE.
module stash_ctrl #(
  parameter int unsigned DEPTH          = 10,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_browse,
  input  logic [7:0] time_in,
  output logic       run_en,
  output logic       timer_clear,
  output logic [7:0] stash_sample_in,
  output logic       stash_sample_in_valid,
  output logic       stash_next_sample,
  output logic       disp_sel,
  output logic [3:0] lap_count,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_STOP   = 2'b10;
  localparam logic [1:0] ST_BROWSE = 2'b11;

  localparam logic [3:0]  DEPTH_L  = 4'(DEPTH);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [3:0]  step_cnt;
  logic [31:0] idle_cnt;

  // Stash interface: stash_sample_in_valid and stash_next_sample are one-cycle
  // strobes with no ready/back-pressure; the buffer must accept them on the cycle
  // they are high. They come from mutually exclusive states, so never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= ST_IDLE;
      run_en                <= 1'b0;
      timer_clear           <= 1'b0;
      stash_sample_in       <= 8'h00;
      stash_sample_in_valid <= 1'b0;
      stash_next_sample     <= 1'b0;
      disp_sel              <= 1'b0;
      lap_count             <= 4'd0;
      step_cnt              <= 4'd0;
      idle_cnt              <= 32'd0;
    end else begin
      timer_clear           <= 1'b0;
      stash_sample_in_valid <= 1'b0;
      stash_next_sample     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_start_stop) begin
            state       <= ST_RUN;
            run_en      <= 1'b1;
            timer_clear <= 1'b1;
          end
        end
        ST_RUN: begin
          // A lap pressed together with stop is still captured.
          if (btn_lap) begin
            stash_sample_in       <= time_in;
            stash_sample_in_valid <= 1'b1;
            if (lap_count < DEPTH_L) lap_count <= lap_count + 4'd1;
          end
          if (btn_start_stop) begin
            state  <= ST_STOP;
            run_en <= 1'b0;
          end
        end
        ST_STOP: begin
          if (btn_start_stop) begin
            state  <= ST_RUN;
            run_en <= 1'b1;
          end else if (btn_lap) begin
            state       <= ST_IDLE;
            timer_clear <= 1'b1;
            lap_count   <= 4'd0;
          end else if (btn_browse && lap_count != 4'd0) begin
            state    <= ST_BROWSE;
            disp_sel <= 1'b1;
            step_cnt <= 4'd0;
            idle_cnt <= 32'd0;
          end
        end
        default: begin
          if (btn_start_stop) begin
            state    <= ST_RUN;
            run_en   <= 1'b1;
            disp_sel <= 1'b0;
            idle_cnt <= 32'd0;
          end else if (btn_browse) begin
            idle_cnt <= 32'd0;
            step_cnt <= step_cnt + 4'd1;
            // The last stored lap is already on display; wrap back to STOP.
            if (step_cnt == lap_count - 4'd1) begin
              state    <= ST_STOP;
              disp_sel <= 1'b0;
            end else begin
              stash_next_sample <= 1'b1;
            end
          end else if (btn_lap) begin
            idle_cnt <= 32'd0;
          end else if (idle_cnt == TMO_LAST) begin
            state    <= ST_STOP;
            disp_sel <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule
